// File: rtl/acc_trig_uploader_if.sv
// Upload stream toward the host link: 32-bit words with valid/ready flow control,
// up_last marks the tail word of each frame.
interface acc_trig_uploader_if;
   logic        up_valid;
   logic        up_ready;
   logic [31:0] up_data;
   logic        up_last;

   modport master (
      output up_valid,
      output up_data,
      output up_last,
      input  up_ready
   );

   modport slave (
      input  up_valid,
      input  up_data,
      input  up_last,
      output up_ready
   );
endinterface

// File: rtl/acc_trig_uploader.sv
// Drains the acc-trigger encoder log FIFO and packs entries into framed 32-bit words:
// header {tag, seq}, HI/LO word per entry, tail {count, folded XOR checksum}.
// Frames close when full, after an idle timeout, or when the scan ends.
module acc_trig_uploader #(
   parameter int unsigned FRAME_WORDS   = 16,
   parameter int unsigned FLUSH_TIMEOUT = 1000,
   parameter logic [15:0] HDR_TAG       = 16'h55AA
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       laser_start_i,
   input  logic                       trig_fifo_ready_i,
   output logic                       trig_fifo_rd_o,
   input  logic [63:0]                trig_fifo_data_i,
   acc_trig_uploader_if.master        up,
   output logic [31:0]                frame_cnt_o,
   output logic [31:0]                word_cnt_o
);

   localparam int unsigned TimerW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
   localparam logic [TimerW-1:0] TimerLast = TimerW'(FLUSH_TIMEOUT - 1);
   localparam logic [16:0] FrameFull = 17'(FRAME_WORDS);

   typedef enum logic [2:0] {StIdle, StHdr, StRd, StWait, StHi, StLo, StTail} state_e;

   state_e              state_q, state_d;
   logic [15:0]         frame_seq_q, frame_seq_d;
   logic [31:0]         frame_cnt_q, frame_cnt_d;
   logic [31:0]         word_cnt_q, word_cnt_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [31:0]         csum_q, csum_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [63:0]         entry_q, entry_d;
   logic                laser_q, laser_d;
   logic                clear_pend_q, clear_pend_d;
   logic                end_pend_q, end_pend_d;

   logic                rise, fall, xfer;
   logic                up_valid, up_last, fifo_rd;
   logic [31:0]         up_data;

   // Next-state, frame bookkeeping and stream outputs
   always_comb begin
      state_d      = state_q;
      frame_seq_d  = frame_seq_q;
      frame_cnt_d  = frame_cnt_q;
      word_cnt_d   = word_cnt_q;
      cnt_d        = cnt_q;
      csum_d       = csum_q;
      timer_d      = timer_q;
      entry_d      = entry_q;
      fifo_rd      = 1'b0;
      up_valid     = 1'b0;
      up_last      = 1'b0;
      up_data      = 32'h0;

      rise         = laser_start_i & ~laser_q;
      fall         = ~laser_start_i & laser_q;
      laser_d      = laser_start_i;
      clear_pend_d = clear_pend_q | rise;
      end_pend_d   = end_pend_q | fall;
      xfer         = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A scan restart only takes effect between frames
            if (clear_pend_q) begin
               frame_seq_d  = 16'h0;
               frame_cnt_d  = 32'h0;
               word_cnt_d   = 32'h0;
               clear_pend_d = rise;
            end
            // A scan end seen between frames has nothing left to flush
            end_pend_d = fall;
            if (trig_fifo_ready_i) begin
               state_d = StHdr;
            end
         end
         StHdr: begin
            up_valid = 1'b1;
            up_data  = {HDR_TAG, frame_seq_q};
            xfer     = up.up_ready;
            if (xfer) begin
               cnt_d   = 16'h0;
               csum_d  = 32'h0;
               timer_d = '0;
               state_d = StRd;
            end
         end
         StRd: begin
            if (trig_fifo_ready_i) begin
               fifo_rd = 1'b1;
               timer_d = '0;
               state_d = StWait;
            end else if (timer_q == TimerLast || end_pend_q) begin
               state_d = StTail;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StWait: begin
            entry_d = trig_fifo_data_i;
            state_d = StHi;
         end
         StHi: begin
            up_valid = 1'b1;
            up_data  = entry_q[63:32];
            xfer     = up.up_ready;
            if (xfer) begin
               csum_d  = csum_q ^ entry_q[63:32];
               state_d = StLo;
            end
         end
         StLo: begin
            up_valid = 1'b1;
            up_data  = entry_q[31:0];
            xfer     = up.up_ready;
            if (xfer) begin
               csum_d     = csum_q ^ entry_q[31:0];
               cnt_d      = cnt_q + 16'd1;
               word_cnt_d = word_cnt_q + 32'd1;
               if (({1'b0, cnt_q} + 17'd1) == FrameFull || end_pend_q) begin
                  state_d = StTail;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StTail: begin
            up_valid = 1'b1;
            up_last  = 1'b1;
            up_data  = {cnt_q, csum_q[31:16] ^ csum_q[15:0]};
            xfer     = up.up_ready;
            if (xfer) begin
               frame_seq_d = frame_seq_q + 16'd1;
               frame_cnt_d = frame_cnt_q + 32'd1;
               end_pend_d  = fall;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         frame_seq_q  <= 16'h0;
         frame_cnt_q  <= 32'h0;
         word_cnt_q   <= 32'h0;
         cnt_q        <= 16'h0;
         csum_q       <= 32'h0;
         timer_q      <= '0;
         entry_q      <= 64'h0;
         laser_q      <= 1'b0;
         clear_pend_q <= 1'b0;
         end_pend_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_seq_q  <= frame_seq_d;
         frame_cnt_q  <= frame_cnt_d;
         word_cnt_q   <= word_cnt_d;
         cnt_q        <= cnt_d;
         csum_q       <= csum_d;
         timer_q      <= timer_d;
         entry_q      <= entry_d;
         laser_q      <= laser_d;
         clear_pend_q <= clear_pend_d;
         end_pend_q   <= end_pend_d;
      end
   end

   assign trig_fifo_rd_o = fifo_rd;
   assign up.up_valid    = up_valid;
   assign up.up_data     = up_data;
   assign up.up_last     = up_last;
   assign frame_cnt_o    = frame_cnt_q;
   assign word_cnt_o     = word_cnt_q;

endmodule

// File: tb/tb_acc_trig_uploader.sv
// Directed bench for acc_trig_uploader: FIFO model, stream capture, stall and read-ordering monitors.
module tb_acc_trig_uploader;

   localparam int unsigned FW = 16;
   localparam int unsigned FT = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        laser;
   logic        fifo_rd;
   logic        fifo_ready;
   logic [63:0] fifo_data = 64'h0;
   logic [31:0] frame_cnt;
   logic [31:0] word_cnt;

   acc_trig_uploader_if up_if ();

   acc_trig_uploader #(
      .FRAME_WORDS   (FW),
      .FLUSH_TIMEOUT (FT),
      .HDR_TAG       (16'h55AA)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .laser_start_i     (laser),
      .trig_fifo_ready_i (fifo_ready),
      .trig_fifo_rd_o    (fifo_rd),
      .trig_fifo_data_i  (fifo_data),
      .up                (up_if),
      .frame_cnt_o       (frame_cnt),
      .word_cnt_o        (word_cnt)
   );

   always #5 clk = ~clk;

   int vec = 0;
   int mis = 0;

   // FIFO model: data appears exactly one cycle after the read pulse
   logic [63:0] fmem [0:255];
   logic [7:0]  wr_ptr = 8'd0;
   logic [7:0]  rd_ptr = 8'd0;
   logic [63:0] ents [$];
   assign fifo_ready = (wr_ptr != rd_ptr);

   always @(posedge clk) begin
      if (fifo_rd) begin
         fifo_data <= fmem[rd_ptr];
         rd_ptr    <= rd_ptr + 8'd1;
      end
   end

   // Sink ready: always high, or randomly low about 30% of cycles
   bit rand_ready = 1'b0;
   always @(negedge clk) begin
      up_if.up_ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
   end

   // Capture of every transferred word with its cycle stamp
   int          cyc = 0;
   logic [31:0] cap_w [$];
   logic        cap_l [$];
   int          cap_c [$];
   logic [31:0] exp_w [$];
   logic        exp_l [$];

   wire xfer = up_if.up_valid && up_if.up_ready;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && xfer) begin
         cap_w.push_back(up_if.up_data);
         cap_l.push_back(up_if.up_last);
         cap_c.push_back(cyc);
      end
   end

   // Stall stability and outstanding-entry monitors
   int          stall_err = 0;
   int          stall_cnt = 0;
   int          rd_err = 0;
   int          pend = 0;
   bit          stall_prev = 1'b0;
   logic [31:0] hold_d = 32'h0;
   logic        hold_l = 1'b0;
   bit          expect_hdr = 1'b1;
   bit          lo_next = 1'b0;
   wire         xfer_lo = xfer && !up_if.up_last && !expect_hdr && lo_next;

   always @(posedge clk) begin
      if (rst) begin
         stall_prev <= 1'b0;
         pend       <= 0;
         expect_hdr <= 1'b1;
         lo_next    <= 1'b0;
      end else begin
         if (stall_prev && (!up_if.up_valid || up_if.up_data !== hold_d ||
                            up_if.up_last !== hold_l))
            stall_err <= stall_err + 1;
         if (up_if.up_valid && !up_if.up_ready) stall_cnt <= stall_cnt + 1;
         stall_prev <= up_if.up_valid && !up_if.up_ready;
         hold_d     <= up_if.up_data;
         hold_l     <= up_if.up_last;
         if (fifo_rd && pend != 0) rd_err <= rd_err + 1;
         if (fifo_rd && (up_if.up_valid || fifo_ready === 1'bx)) rd_err <= rd_err + 1;
         pend <= pend + (fifo_rd ? 1 : 0) - (xfer_lo ? 1 : 0);
         if (xfer) begin
            if (up_if.up_last) begin
               expect_hdr <= 1'b1;
            end else if (expect_hdr) begin
               expect_hdr <= 1'b0;
               lo_next    <= 1'b0;
            end else begin
               lo_next <= !lo_next;
            end
         end
      end
   end

   function automatic logic [63:0] mk_ent(input int w, input int x);
      return {24'd0, 2'd0, w[17:0], 2'd0, x[17:0]};
   endfunction

   task automatic push_entry(input logic [63:0] e);
      fmem[wr_ptr] = e;
      wr_ptr = wr_ptr + 8'd1;
      ents.push_back(e);
   endtask

   // Expected frame built from the entry list
   task automatic add_frame(input logic [15:0] seq, input int first, input int n);
      logic [31:0] cs = 32'h0;
      exp_w.push_back({16'h55AA, seq});
      exp_l.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         cs = cs ^ ents[first + i][63:32] ^ ents[first + i][31:0];
         exp_w.push_back(ents[first + i][63:32]);
         exp_l.push_back(1'b0);
         exp_w.push_back(ents[first + i][31:0]);
         exp_l.push_back(1'b0);
      end
      exp_w.push_back({n[15:0], cs[31:16] ^ cs[15:0]});
      exp_l.push_back(1'b1);
   endtask

   task automatic wait_words(input int n, input int budget);
      int k = 0;
      while (cap_w.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      wr_ptr = rd_ptr;
      repeat (2) @(negedge clk);
      cap_w.delete();
      cap_l.delete();
      cap_c.delete();
      exp_w.delete();
      exp_l.delete();
      ents.delete();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      laser = 1'b0;
      push_entry(64'h0003_0001_0002_0004);
      repeat (3) @(negedge clk);
      vec++;
      if (up_if.up_valid !== 1'b0) begin
         mis++; $display("FAIL reset valid: got %b want 0", up_if.up_valid);
      end
      vec++;
      if (up_if.up_data !== 32'h0) begin
         mis++; $display("FAIL reset data: got %h want 00000000", up_if.up_data);
      end
      vec++;
      if (up_if.up_last !== 1'b0 || fifo_rd !== 1'b0) begin
         mis++; $display("FAIL reset last/rd: got %b/%b want 0/0", up_if.up_last, fifo_rd);
      end
      vec++;
      if (frame_cnt !== 32'h0 || word_cnt !== 32'h0) begin
         mis++; $display("FAIL reset counters: got %0d/%0d want 0/0", frame_cnt, word_cnt);
      end
      rst = 1'b0;
      @(negedge clk);
      vec++;
      if (up_if.up_valid !== 1'b1 || up_if.up_data !== 32'h55AA0000) begin
         mis++;
         $display("FAIL reset header: got valid %b data %h want 1 55aa0000",
                  up_if.up_valid, up_if.up_data);
      end
   endtask

   task automatic test_single();
      exp_w = '{32'h55AA0000, 32'h00030001, 32'h00020004, 32'h00010004};
      exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
      wait_words(4, FT + 50);
      vec++;
      if (cap_w.size() < 4) begin
         mis++; $display("FAIL single timeout: got %0d words want 4", cap_w.size());
      end
      for (int i = 0; i < exp_w.size(); i++) begin
         vec++;
         if (i >= cap_w.size() || cap_w[i] !== exp_w[i] || cap_l[i] !== exp_l[i]) begin
            mis++;
            $display("FAIL single word %0d: got %h last %b want %h last %b",
                     i, cap_w[i], cap_l[i], exp_w[i], exp_l[i]);
         end
      end
      vec++;
      if (cap_w.size() >= 4 && (cap_c[3] - cap_c[2]) != FT + 1) begin
         mis++; $display("FAIL single timeout gap: got %0d want %0d", cap_c[3] - cap_c[2], FT + 1);
      end
      vec++;
      if (frame_cnt !== 32'd1 || word_cnt !== 32'd1) begin
         mis++; $display("FAIL single counters: got %0d/%0d want 1/1", frame_cnt, word_cnt);
      end
   endtask

   task automatic test_multi_frame();
      do_reset();
      for (int i = 0; i < 40; i++) push_entry(mk_ent(i * 3 + 1, i * 7 + 5));
      add_frame(16'd0, 0, 16);
      add_frame(16'd1, 16, 16);
      add_frame(16'd2, 32, 8);
      wait_words(86, 2000);
      vec++;
      if (cap_w.size() < 86) begin
         mis++; $display("FAIL multi timeout: got %0d words want 86", cap_w.size());
      end
      for (int i = 0; i < exp_w.size(); i++) begin
         vec++;
         if (i >= cap_w.size() || cap_w[i] !== exp_w[i] || cap_l[i] !== exp_l[i]) begin
            mis++;
            $display("FAIL multi word %0d: got %h last %b want %h last %b",
                     i, cap_w[i], cap_l[i], exp_w[i], exp_l[i]);
         end
      end
      vec++;
      if (frame_cnt !== 32'd3 || word_cnt !== 32'd40) begin
         mis++; $display("FAIL multi counters: got %0d/%0d want 3/40", frame_cnt, word_cnt);
      end
   endtask

   task automatic test_back_pressure();
      int stalls0;
      do_reset();
      stalls0    = stall_cnt;
      rand_ready = 1'b1;
      for (int i = 0; i < 20; i++) push_entry(mk_ent(i * 11 + 3, 1000 + i * 13));
      add_frame(16'd0, 0, 16);
      add_frame(16'd1, 16, 4);
      wait_words(44, 3000);
      rand_ready = 1'b0;
      vec++;
      if (cap_w.size() < 44) begin
         mis++; $display("FAIL backpressure timeout: got %0d words want 44", cap_w.size());
      end
      for (int i = 0; i < exp_w.size(); i++) begin
         vec++;
         if (i >= cap_w.size() || cap_w[i] !== exp_w[i] || cap_l[i] !== exp_l[i]) begin
            mis++;
            $display("FAIL backpressure word %0d: got %h last %b want %h last %b",
                     i, cap_w[i], cap_l[i], exp_w[i], exp_l[i]);
         end
      end
      vec++;
      if (stall_cnt == stalls0) begin
         mis++; $display("FAIL backpressure stalls: got 0 stall cycles want >0");
      end
      vec++;
      if (stall_err != 0) begin
         mis++; $display("FAIL stall stability: got %0d changes want 0", stall_err);
      end
      vec++;
      if (rd_err != 0) begin
         mis++; $display("FAIL read ordering: got %0d early reads want 0", rd_err);
      end
   endtask

   task automatic test_scan_end();
      int k = 0;
      do_reset();
      laser = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 16; i++) push_entry(mk_ent(i + 100, i + 200));
      add_frame(16'd0, 0, 5);
      add_frame(16'd1, 5, 11);
      // Drop the scan while entry 5 HI is on the bus
      while (!(up_if.up_valid && cap_w.size() == 9) && k < 200) begin
         @(negedge clk);
         k++;
      end
      vec++;
      if (!(up_if.up_valid && cap_w.size() == 9)) begin
         mis++; $display("FAIL scan_end entry5: got %0d words want 9", cap_w.size());
      end
      laser = 1'b0;
      wait_words(36, 1000);
      vec++;
      if (cap_w.size() < 36) begin
         mis++; $display("FAIL scan_end timeout: got %0d words want 36", cap_w.size());
      end
      for (int i = 0; i < exp_w.size(); i++) begin
         vec++;
         if (i >= cap_w.size() || cap_w[i] !== exp_w[i] || cap_l[i] !== exp_l[i]) begin
            mis++;
            $display("FAIL scan_end word %0d: got %h last %b want %h last %b",
                     i, cap_w[i], cap_l[i], exp_w[i], exp_l[i]);
         end
      end
      vec++;
      if (cap_w.size() >= 12 && (cap_c[11] - cap_c[10]) != 1) begin
         mis++; $display("FAIL scan_end tail gap: got %0d want 1", cap_c[11] - cap_c[10]);
      end
      vec++;
      if (frame_cnt !== 32'd2 || word_cnt !== 32'd16) begin
         mis++; $display("FAIL scan_end counters: got %0d/%0d want 2/16", frame_cnt, word_cnt);
      end
   endtask

   task automatic test_scan_restart();
      cap_w.delete();
      cap_l.delete();
      cap_c.delete();
      exp_w.delete();
      exp_l.delete();
      ents.delete();
      for (int i = 0; i < 3; i++) push_entry(mk_ent(i + 7, i + 9));
      add_frame(16'd2, 0, 3);
      wait_words(2, 200);
      laser = 1'b1;
      wait_words(8, 500);
      repeat (2) @(negedge clk);
      vec++;
      if (frame_cnt !== 32'd0 || word_cnt !== 32'd0) begin
         mis++; $display("FAIL restart clear: got %0d/%0d want 0/0", frame_cnt, word_cnt);
      end
      for (int i = 0; i < 2; i++) push_entry(mk_ent(i + 50, i + 60));
      add_frame(16'd0, 3, 2);
      wait_words(14, 500);
      vec++;
      if (cap_w.size() < 14) begin
         mis++; $display("FAIL restart timeout: got %0d words want 14", cap_w.size());
      end
      for (int i = 0; i < exp_w.size(); i++) begin
         vec++;
         if (i >= cap_w.size() || cap_w[i] !== exp_w[i] || cap_l[i] !== exp_l[i]) begin
            mis++;
            $display("FAIL restart word %0d: got %h last %b want %h last %b",
                     i, cap_w[i], cap_l[i], exp_w[i], exp_l[i]);
         end
      end
      vec++;
      if (frame_cnt !== 32'd1 || word_cnt !== 32'd2) begin
         mis++; $display("FAIL restart counters: got %0d/%0d want 1/2", frame_cnt, word_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi_frame();
      test_back_pressure();
      test_scan_end();
      test_scan_restart();
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
